// File: rtl/instr_decode_front.sv
// Decode front end for the multicycle CPU.
// Holds the instruction register, the NZCV flag register and the
// load-multiple word counter. From them it derives the control unit's
// decision inputs: Op, Perform and LMC.
module instr_decode_front #(
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [IWIDTH-1:0] MemData,
  input  logic              IW,
  input  logic              FU,
  input  logic              ALUN,
  input  logic              ALUZ,
  input  logic              ALUC,
  input  logic              ALUV,
  input  logic [1:0]        LM,
  output logic [3:0]        Op,
  output logic              Perform,
  output logic              LMC,
  output logic [IWIDTH-1:0] IR,
  output logic [3:0]        Flags,
  output logic [CWIDTH-1:0] LMCount
);

  logic [IWIDTH-1:0] ir_q, ir_d;
  logic [3:0]        flags_q, flags_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;

  logic [3:0] cond;
  logic       flag_n, flag_z, flag_c, flag_v, signed_lt;

  // Next-state selection for IR, flags and the load-multiple counter.
  // A counter load samples the IR value held before this edge, so an
  // IW on the same edge never feeds the new word into the count.
  always_comb begin
    ir_d    = ir_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (IW) begin
      ir_d = MemData;
    end
    if (FU) begin
      flags_d = {ALUN, ALUZ, ALUC, ALUV};
    end
    case (LM)
      2'b01:   cnt_d = ir_q[CWIDTH-1:0];
      2'b10:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - CWIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset dominates every write enable and abandons
  // any load-multiple sequence in progress.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cond      = ir_q[IWIDTH-5:IWIDTH-8];
  assign flag_n    = flags_q[3];
  assign flag_z    = flags_q[2];
  assign flag_c    = flags_q[1];
  assign flag_v    = flags_q[0];
  assign signed_lt = flag_n ^ flag_v;

  // Condition evaluation against the registered flags only; a flag
  // update is seen by Perform from the following cycle.
  always_comb begin
    Perform = 1'b0;
    case (cond)
      4'h0:    Perform = 1'b1;
      4'h1:    Perform = flag_z;
      4'h2:    Perform = ~flag_z;
      4'h3:    Perform = signed_lt;
      4'h4:    Perform = ~signed_lt;
      4'h5:    Perform = flag_c;
      4'h6:    Perform = ~flag_c;
      4'h7:    Perform = flag_n;
      4'h8:    Perform = ~flag_n;
      4'h9:    Perform = flag_v;
      4'hA:    Perform = ~flag_v;
      4'hB:    Perform = ~flag_z & ~signed_lt;
      4'hC:    Perform = flag_z | signed_lt;
      default: Perform = 1'b0;
    endcase
  end

  assign Op      = ir_q[IWIDTH-1:IWIDTH-4];
  assign LMC     = (cnt_q == '0);
  assign IR      = ir_q;
  assign Flags   = flags_q;
  assign LMCount = cnt_q;

endmodule

// File: tb/tb_instr_decode_front.sv
// Directed self-checking bench for instr_decode_front.
module tb_instr_decode_front;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] MemData;
  logic        IW, FU, ALUN, ALUZ, ALUC, ALUV;
  logic [1:0]  LM;
  logic [3:0]  Op;
  logic        Perform, LMC;
  logic [15:0] IR;
  logic [3:0]  Flags;
  logic [3:0]  LMCount;

  int checks   = 0;
  int failures = 0;

  instr_decode_front #(.IWIDTH(16), .CWIDTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .MemData(MemData), .IW(IW), .FU(FU),
    .ALUN(ALUN), .ALUZ(ALUZ), .ALUC(ALUC), .ALUV(ALUV), .LM(LM),
    .Op(Op), .Perform(Perform), .LMC(LMC), .IR(IR), .Flags(Flags),
    .LMCount(LMCount)
  );

  always #5 CLK = ~CLK;

  // One rising edge, then settle 1 time unit before any sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 1'b0; IW = 1'b0; FU = 1'b0; LM = 2'b00;
    MemData = 16'h0000; {ALUN, ALUZ, ALUC, ALUV} = 4'b0000;
  endtask

  task automatic fetch(input logic [15:0] word);
    idle(); IW = 1'b1; MemData = word; tick(); idle();
  endtask

  task automatic set_flags(input logic [3:0] nzcv);
    idle(); FU = 1'b1; {ALUN, ALUZ, ALUC, ALUV} = nzcv; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); RESET = 1'b1; tick();
    fetch(16'h7C03); set_flags(4'b1111);
    idle(); LM = 2'b01; tick();
    // Reset with every write enable fighting it.
    RESET = 1'b1; IW = 1'b1; MemData = 16'hFFFF; FU = 1'b1;
    {ALUN, ALUZ, ALUC, ALUV} = 4'b1111; LM = 2'b01; tick(); idle();
    $display("reset: IR=%h Flags=%b LMCount=%0d Op=%h Perform=%b LMC=%b", IR, Flags, LMCount, Op, Perform, LMC);
    checks++; if (IR !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", IR); end
    checks++; if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    checks++; if (LMCount !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", LMCount); end
    checks++; if (Op !== 4'h0) begin failures++; $display("FAIL reset_op got=%h exp=0", Op); end
    checks++; if (Perform !== 1'b1) begin failures++; $display("FAIL reset_perform got=%b exp=1", Perform); end
    checks++; if (LMC !== 1'b1) begin failures++; $display("FAIL reset_lmc got=%b exp=1", LMC); end
  endtask

  task automatic test_fetch();
    fetch(16'h5123);
    $display("fetch: IR=%h Op=%h Perform=%b", IR, Op, Perform);
    checks++; if (IR !== 16'h5123) begin failures++; $display("FAIL fetch_ir got=%h exp=5123", IR); end
    checks++; if (Op !== 4'h5) begin failures++; $display("FAIL fetch_op got=%h exp=5", Op); end
    checks++; if (Perform !== 1'b0) begin failures++; $display("FAIL fetch_eq_z0 got=%b exp=0", Perform); end
    // Compare in flight: Perform still reflects the old flags.
    idle(); FU = 1'b1; ALUZ = 1'b1; #1;
    checks++; if (Perform !== 1'b0) begin failures++; $display("FAIL fetch_no_forward got=%b exp=0", Perform); end
    tick(); idle();
    $display("fetch cmp: Flags=%b Perform=%b", Flags, Perform);
    checks++; if (Flags !== 4'b0100) begin failures++; $display("FAIL fetch_flags got=%b exp=0100", Flags); end
    checks++; if (Perform !== 1'b1) begin failures++; $display("FAIL fetch_eq_z1 got=%b exp=1", Perform); end
  endtask

  task automatic test_signed_compare();
    fetch(16'h7C00);
    set_flags(4'b1000);
    $display("le N=1 V=0: Perform=%b", Perform);
    checks++; if (Perform !== 1'b1) begin failures++; $display("FAIL le_lt got=%b exp=1", Perform); end
    set_flags(4'b0000);
    $display("le all0: Perform=%b", Perform);
    checks++; if (Perform !== 1'b0) begin failures++; $display("FAIL le_gt got=%b exp=0", Perform); end
    set_flags(4'b1001);
    $display("le N=1 V=1: Perform=%b", Perform);
    checks++; if (Perform !== 1'b0) begin failures++; $display("FAIL le_nv got=%b exp=0", Perform); end
  endtask

  task automatic test_load_multiple();
    logic [3:0] exp_cnt [4];
    exp_cnt = '{4'd2, 4'd1, 4'd0, 4'd0};
    fetch(16'h2003);
    idle(); LM = 2'b01; tick(); idle();
    $display("lm load: LMCount=%0d LMC=%b", LMCount, LMC);
    checks++; if (LMCount !== 4'd3) begin failures++; $display("FAIL lm_load got=%0d exp=3", LMCount); end
    checks++; if (LMC !== 1'b0) begin failures++; $display("FAIL lm_load_lmc got=%b exp=0", LMC); end
    for (int i = 0; i < 4; i++) begin
      idle(); LM = 2'b10; tick(); idle();
      $display("lm dec %0d: LMCount=%0d LMC=%b", i, LMCount, LMC);
      checks++; if (LMCount !== exp_cnt[i]) begin failures++; $display("FAIL lm_dec%0d got=%0d exp=%0d", i, LMCount, exp_cnt[i]); end
      checks++; if (LMC !== (exp_cnt[i] == 4'd0)) begin failures++; $display("FAIL lm_dec%0d_lmc got=%b exp=%b", i, LMC, exp_cnt[i] == 4'd0); end
    end
    // Hold codes 00 and 11 keep the count.
    fetch(16'h0009);
    idle(); LM = 2'b01; tick();
    idle(); LM = 2'b11; tick(); idle(); tick();
    $display("lm hold: LMCount=%0d", LMCount);
    checks++; if (LMCount !== 4'd9) begin failures++; $display("FAIL lm_hold got=%0d exp=9", LMCount); end
  endtask

  task automatic test_collision();
    fetch(16'h0005);
    idle(); IW = 1'b1; MemData = 16'h000A; LM = 2'b01; tick(); idle();
    $display("collision: LMCount=%0d IR=%h", LMCount, IR);
    checks++; if (LMCount !== 4'd5) begin failures++; $display("FAIL coll_cnt got=%0d exp=5", LMCount); end
    checks++; if (IR !== 16'h000A) begin failures++; $display("FAIL coll_ir got=%h exp=000A", IR); end
    fetch(16'h0010);
    idle(); LM = 2'b01; tick(); idle();
    $display("zero count: LMCount=%0d LMC=%b", LMCount, LMC);
    checks++; if (LMC !== 1'b1) begin failures++; $display("FAIL zero_cnt_lmc got=%b exp=1", LMC); end
  endtask

  task automatic test_reset_mid_count();
    fetch(16'h0004);
    idle(); LM = 2'b01; tick(); idle();
    checks++; if (LMCount !== 4'd4) begin failures++; $display("FAIL mid_pre got=%0d exp=4", LMCount); end
    idle(); LM = 2'b10; RESET = 1'b1; tick(); idle();
    $display("reset mid count: LMCount=%0d LMC=%b", LMCount, LMC);
    checks++; if (LMCount !== 4'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", LMCount); end
    checks++; if (LMC !== 1'b1) begin failures++; $display("FAIL mid_lmc got=%b exp=1", LMC); end
  endtask

  // Hand-written condition table in NZCV terms.
  function automatic logic cond_table(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return n != v;
      4'h4: return n == v;
      4'h5: return cy;
      4'h6: return !cy;
      4'h7: return n;
      4'h8: return !n;
      4'h9: return v;
      4'hA: return !v;
      4'hB: return !z && (n == v);
      4'hC: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_cond_sweep();
    logic exp_p;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        // IR and flags written on the same edge.
        idle(); IW = 1'b1; MemData = {4'h3, 4'(c), 8'hA5}; FU = 1'b1;
        {ALUN, ALUZ, ALUC, ALUV} = 4'(f); tick(); idle();
        exp_p = cond_table(4'(c), 4'(f));
        $display("sweep cond=%h nzcv=%b Perform=%b", c, f[3:0], Perform);
        checks++; if (Perform !== exp_p) begin failures++; $display("FAIL sweep cond=%h nzcv=%b got=%b exp=%b", c, f[3:0], Perform, exp_p); end
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fetch();
    test_signed_compare();
    test_load_multiple();
    test_collision();
    test_reset_mid_count();
    test_cond_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode_front.md
Name: instr_decode_front

Overview:
- Upstream neighbour of ControlUnitFast in the multicycle CPU.
- Holds the instruction register, the condition-flag register and the load-multiple word counter.
- Produces the control unit's decision inputs:
  - Op, the opcode.
  - Perform, the condition-pass signal.
  - LMC, load-multiple complete.
- Consumes IW, FU and LM from the control unit, closing the loop with it.

Parameters:
- IWIDTH, 16, instruction word width; Op is always the top 4 bits.
- CWIDTH, 4, load-multiple counter width; the count is loaded from IR[CWIDTH-1:0].

Ports:
- CLK  in  1  system clock; the only clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MemData  in  IWIDTH  memory read data; instruction source.
- IW  in  1  instruction write; IR <= MemData.
- FU  in  1  flag update; flags <= {ALUN, ALUZ, ALUC, ALUV}.
- ALUN  in  1  ALU negative result.
- ALUZ  in  1  ALU zero result.
- ALUC  in  1  ALU carry-out.
- ALUV  in  1  ALU signed overflow.
- LM  in  2  load-multiple counter command: 00 hold, 01 load, 10 decrement, 11 hold.
- Op  out  4  IR[IWIDTH-1:IWIDTH-4].
- Perform  out  1  condition field IR[IWIDTH-5:IWIDTH-8] evaluated against the registered flags.
- LMC  out  1  1 when the counter is 0.
- IR  out  IWIDTH  instruction register contents.
- Flags  out  4  {N,Z,C,V} registered flags.
- LMCount  out  CWIDTH  counter value.

Behaviour:
- Reset, on a rising CLK edge with RESET=1:
  - IR=0, Flags=0, LMCount=0.
  - Hence Op=0, Perform=1 (cond 0 = always), LMC=1.
  - RESET overrides IW, FU and LM in the same cycle.
  - Reset in the middle of a load-multiple sequence abandons it; the count goes to 0.
- IR:
  - Loads MemData at the edge where IW=1; otherwise holds.
  - Op is visible the cycle after that edge (1-cycle latency).
  - Op is purely a combinational slice of IR; no extra register.
- Flags:
  - Load at the edge where FU=1; otherwise hold.
  - No forwarding: Perform always uses the registered flags.
  - A compare (FU=1) in cycle n affects Perform from cycle n+1.
- Perform, combinational from IR and Flags, by cond code:
  - 0 AL: 1.
  - 1 EQ: Z.
  - 2 NE: ~Z.
  - 3 LT: N^V.
  - 4 GE: ~(N^V).
  - 5 CS: C.
  - 6 CC: ~C.
  - 7 MI: N.
  - 8 PL: ~N.
  - 9 VS: V.
  - A VC: ~V.
  - B GT: ~Z & ~(N^V).
  - C LE: Z | (N^V).
  - D-F NV: 0.
- Load-multiple counter:
  - LM=01: LMCount <= IR[CWIDTH-1:0], taken from the IR value before this edge.
  - LM=10: LMCount <= LMCount-1, saturating at 0 (no wrap to all-ones).
  - LM=00 or LM=11: hold.
  - LMC = (LMCount==0), combinational.
  - Loading a count of 0 gives LMC=1 on the next cycle; the control unit sees an immediate completion.
- Simultaneous events:
  - IW=1 with LM=01: the counter takes the old IR field; IR takes the new word.
  - IW=1 with FU=1: both registers update independently.
  - FU=1 while Perform is being sampled: the control unit sees the old Perform in that cycle.
- Implementation constraints:
  - No latches; all outputs are defined for every input combination.
  - Unknown cond codes are not possible: all 16 values are covered above.

Test Plan:
- Reset: RESET=1 for one edge with IW=1, MemData=16'hFFFF, FU=1, LM=01 -> IR=0, Flags=0, LMCount=0, Op=0, Perform=1, LMC=1.
- Fetch: IW=1, MemData=16'h5123 -> after the edge Op=5 and IR=16'h5123, which decodes as cond 1 (EQ); Flags=0 gives Perform=0. Then FU=1 with ALUZ=1 -> Perform=1 only from the following cycle.
- Signed compare: IR=16'h7C00 (cond C, LE); FU=1 with N=1, V=0 -> Perform=1. Then FU=1 with N=0, Z=0, V=0 -> Perform=0. Finally FU=1 with N=1, V=1, Z=0 -> Perform=0.
- Load-multiple: IR=16'h2003; LM=01 -> LMCount=3, LMC=0. Then LM=10 three times -> 2, 1, 0 with LMC=1 at 0. A fourth LM=10 -> stays 0.
- Load/fetch collision: IR=16'h0005; one edge with IW=1, MemData=16'h000A, LM=01 -> LMCount=5, IR=16'h000A. A zero count (IR[3:0]=0) with LM=01 -> LMC=1 next cycle.
- Reset mid-count: LMCount=4 with LM=10 and RESET=1 on the same edge -> LMCount=0, LMC=1. Then sweep all 16 cond codes against all 16 flag patterns and compare Perform with the table above.
